pipelined_control_unit: RTL

Registered successor to the combinational decode-stage control unit. Decodes the opcode into the control bundle and holds it in the ID/EX control register. Provides a valid/ready handshake, downstream stall and flush, and a configurable branch-shadow bubble counter. Opcode and EX-command widths are parametrised. Sits between the IF/ID register and the EX stage.

---
 rtl/pipelined_control_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_control_unit
//  Description : Decode-stage control unit with a registered ID/EX control
//                bundle. It provides a valid/ready handshake, downstream
//                stall and flush, and a branch-shadow bubble counter.
//                Optional feature macro: ILLEGAL_OP_TRAP_EN. When it is
//                defined, the sticky illegal_op output is added.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_control_unit #(
   parameter int OPCODE_W       = 6,
   parameter int EXCMD_W        = 4,
   parameter int BRANCH_BUBBLES = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode_in,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                stall_in,
   input  logic                flush_in,
   output logic                out_valid,
   output logic [1:0]          cond_check,
   output logic                is_brj,
   output logic                is_imm,
   output logic                st_bne,
   output logic                mem_read,
   output logic                mem_write,
   output logic                wb_en,
`ifdef ILLEGAL_OP_TRAP_EN
   output logic                illegal_op,
`endif
   output logic [EXCMD_W-1:0]  ex_cmd
);

   // A zero bubble count still needs a legal one-bit counter.
   localparam int CNT_W = (BRANCH_BUBBLES > 0) ? $clog2(BRANCH_BUBBLES + 1) : 1;

   typedef enum logic [0:0] {S_RUN = 1'b0, S_SHADOW = 1'b1} state_t;

   typedef struct packed {
      logic       ov;
      logic [1:0] cc;
      logic       brj;
      logic       imm;
      logic       stb;
      logic       mr;
      logic       mw;
      logic       wb;
      logic [3:0] cmd;
   } ctrl_t;

   localparam ctrl_t c_bubble = '{ov: 1'b0, cc: 2'b11, brj: 1'b0, imm: 1'b0, stb: 1'b0,
                                  mr: 1'b0, mw: 1'b0, wb: 1'b0, cmd: 4'h0};

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   ctrl_t                r_ctrl;
   ctrl_t                w_dec;
   logic                 w_illegal;
   logic                 w_is_branch;
   logic                 w_accept;
   logic [OPCODE_W-1:0]  w_hi;
   logic [5:0]           w_op6;
`ifdef ILLEGAL_OP_TRAP_EN
   logic                 r_illegal_op;
`endif

   assign w_hi  = opcode_in >> 6;
   assign w_op6 = opcode_in[5:0];

   // Opcode decode into the control bundle; illegal opcodes fall back to a NOP.
   always_comb begin
      w_dec       = c_bubble;
      w_dec.ov    = 1'b1;
      w_dec.wb    = 1'b1;
      w_illegal   = 1'b0;
      w_is_branch = 1'b0;
      case (w_op6)
         6'd0:        w_dec.wb  = 1'b0;
         6'd1:        w_dec.cmd = 4'b0000;
         6'd2, 6'd3:  w_dec.cmd = 4'b0010;
         6'd4:        w_dec.cmd = 4'b0101;
         6'd5:        w_dec.cmd = 4'b0100;
         6'd6:        w_dec.cmd = 4'b0101;
         6'd7:        w_dec.cmd = 4'b0110;
         6'd8:        w_dec.cmd = 4'b0111;
         6'd9, 6'd10: w_dec.cmd = 4'b1000;
         6'd11:       w_dec.cmd = 4'b1001;
         6'd12:       w_dec.cmd = 4'b1010;
         6'd32: begin w_dec.cmd = 4'b0000; w_dec.imm = 1'b1; end
         6'd33: begin w_dec.cmd = 4'b0010; w_dec.imm = 1'b1; end
         6'd36: begin w_dec.cmd = 4'b0000; w_dec.mr  = 1'b1; end
         6'd37: begin
            w_dec.mw  = 1'b1;
            w_dec.stb = 1'b1;
            w_dec.wb  = 1'b0;
         end
         6'd40, 6'd41, 6'd42: begin
            w_dec.wb    = 1'b0;
            w_dec.brj   = 1'b1;
            w_dec.imm   = 1'b1;
            w_dec.cc    = w_op6[1:0];
            w_dec.stb   = (w_op6 == 6'd41);
            w_is_branch = 1'b1;
         end
         default:     w_illegal = 1'b1;
      endcase
      // Any set bit above bit 5 makes the whole opcode illegal.
      if (w_hi != '0) begin
         w_illegal   = 1'b1;
         w_is_branch = 1'b0;
      end
      if (w_illegal) begin
         w_dec    = c_bubble;
         w_dec.ov = 1'b1;
      end
   end

`ifdef ILLEGAL_OP_TRAP_EN
   assign in_ready = rst & ~stall_in & ~flush_in & (r_state == S_RUN) & ~r_illegal_op;
   assign illegal_op = r_illegal_op;
`else
   assign in_ready = rst & ~stall_in & ~flush_in & (r_state == S_RUN);
`endif

   assign w_accept = in_valid & in_ready;

   // ID/EX control register, branch-shadow FSM and bubble counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ctrl  <= c_bubble;
         r_state <= S_RUN;
         r_cnt   <= '0;
`ifdef ILLEGAL_OP_TRAP_EN
         r_illegal_op <= 1'b0;
`endif
      end else if (flush_in) begin
         // The squashed input is not consumed; upstream re-presents it.
         r_ctrl  <= c_bubble;
         r_state <= S_RUN;
         r_cnt   <= '0;
      end else if (stall_in) begin
         r_ctrl  <= r_ctrl;
      end else if (r_state == S_SHADOW) begin
         r_ctrl <= c_bubble;
         r_cnt  <= r_cnt - CNT_W'(1);
         if (r_cnt == CNT_W'(1)) begin
            r_state <= S_RUN;
         end
      end else if (w_accept) begin
`ifdef ILLEGAL_OP_TRAP_EN
         if (w_illegal) begin
            r_ctrl       <= c_bubble;
            r_illegal_op <= 1'b1;
         end else begin
            r_ctrl <= w_dec;
         end
`else
         r_ctrl <= w_dec;
`endif
         if (w_is_branch && (BRANCH_BUBBLES > 0)) begin
            r_state <= S_SHADOW;
            r_cnt   <= CNT_W'(BRANCH_BUBBLES);
         end
      end else begin
         r_ctrl <= c_bubble;
      end
   end

   assign out_valid  = r_ctrl.ov;
   assign cond_check = r_ctrl.cc;
   assign is_brj     = r_ctrl.brj;
   assign is_imm     = r_ctrl.imm;
   assign st_bne     = r_ctrl.stb;
   assign mem_read   = r_ctrl.mr;
   assign mem_write  = r_ctrl.mw;
   assign wb_en      = r_ctrl.wb;
   assign ex_cmd     = EXCMD_W'(r_ctrl.cmd);

endmodule
`default_nettype wire
